// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the pipelined RV32I core.
// Captures the decode-stage control word and operands and presents them to
// execute one cycle later. Supports hold (stall_E) and bubble insertion
// (flush_E), and produces the load-use hazard detect (lwStall).
// Optional feature: define ID_EX_PERF_CNT_EN to build the saturating
// bubble counter. Without it, bubble_cnt is tied to zero and no counter flops exist.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_D,
  input  logic            stall_E,
  input  logic            flush_E,
  input  logic            RegWrite_D,
  input  logic            MemWrite_D,
  input  logic            Branch_D,
  input  logic            ALUSrc_b_D,
  input  logic [1:0]      Jump_D,
  input  logic [1:0]      ResultSrc_D,
  input  logic [1:0]      ALUSrc_a_D,
  input  logic [3:0]      ALU_Control_D,
  input  logic [2:0]      Funct3_D,
  input  logic [XLEN-1:0] PC_D,
  input  logic [XLEN-1:0] PCPlus4_D,
  input  logic [XLEN-1:0] RD1_D,
  input  logic [XLEN-1:0] RD2_D,
  input  logic [XLEN-1:0] ImmExt_D,
  input  logic [4:0]      Rs1_D,
  input  logic [4:0]      Rs2_D,
  input  logic [4:0]      Rd_D,
  output logic            RegWrite_E,
  output logic            MemWrite_E,
  output logic            Branch_E,
  output logic            ALUSrc_b_E,
  output logic [1:0]      Jump_E,
  output logic [1:0]      ResultSrc_E,
  output logic [1:0]      ALUSrc_a_E,
  output logic [3:0]      ALU_Control_E,
  output logic [2:0]      Funct3_E,
  output logic [XLEN-1:0] PC_E,
  output logic [XLEN-1:0] PCPlus4_E,
  output logic [XLEN-1:0] RD1_E,
  output logic [XLEN-1:0] RD2_E,
  output logic [XLEN-1:0] ImmExt_E,
  output logic [4:0]      Rs1_E,
  output logic [4:0]      Rs2_E,
  output logic [4:0]      Rd_E,
  output logic            valid_E,
  output logic            lwStall,
  output logic [31:0]     bubble_cnt
);

  logic            r_valid;
  logic            r_reg_write;
  logic            r_mem_write;
  logic            r_branch;
  logic            r_alu_src_b;
  logic [1:0]      r_jump;
  logic [1:0]      r_result_src;
  logic [1:0]      r_alu_src_a;
  logic [3:0]      r_alu_control;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;
  logic [XLEN-1:0] r_rd1;
  logic [XLEN-1:0] r_rd2;
  logic [XLEN-1:0] r_imm_ext;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;

  logic            w_load;
  logic            w_clear;
  logic            w_lw_in_e;
  logic            w_rs_match;

  // A flush behaves exactly like reset for the pipeline slot; only the
  // counter distinguishes the two.
  assign w_clear = rst | flush_E;
  assign w_load  = ~stall_E;

  // Pipeline slot: clear on reset/flush, hold on stall, otherwise capture.
  // Side-effect bits are gated by valid_D so an empty slot is always a NOP.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_valid       <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_write   <= 1'b0;
      r_branch      <= 1'b0;
      r_alu_src_b   <= 1'b0;
      r_jump        <= 2'b00;
      r_result_src  <= 2'b00;
      r_alu_src_a   <= 2'b00;
      r_alu_control <= 4'h0;
      r_funct3      <= 3'h0;
      r_pc          <= '0;
      r_pc_plus4    <= '0;
      r_rd1         <= '0;
      r_rd2         <= '0;
      r_imm_ext     <= '0;
      r_rs1         <= 5'd0;
      r_rs2         <= 5'd0;
      r_rd          <= 5'd0;
    end else if (w_load) begin
      r_valid       <= valid_D;
      r_reg_write   <= RegWrite_D & valid_D;
      r_mem_write   <= MemWrite_D & valid_D;
      r_branch      <= Branch_D & valid_D;
      r_alu_src_b   <= ALUSrc_b_D;
      r_jump        <= Jump_D & {2{valid_D}};
      r_result_src  <= ResultSrc_D;
      r_alu_src_a   <= ALUSrc_a_D;
      r_alu_control <= ALU_Control_D;
      r_funct3      <= Funct3_D;
      r_pc          <= PC_D;
      r_pc_plus4    <= PCPlus4_D;
      r_rd1         <= RD1_D;
      r_rd2         <= RD2_D;
      r_imm_ext     <= ImmExt_D;
      r_rs1         <= Rs1_D;
      r_rs2         <= Rs2_D;
      r_rd          <= Rd_D;
    end
  end

  assign valid_E       = r_valid;
  assign RegWrite_E    = r_reg_write;
  assign MemWrite_E    = r_mem_write;
  assign Branch_E      = r_branch;
  assign ALUSrc_b_E    = r_alu_src_b;
  assign Jump_E        = r_jump;
  assign ResultSrc_E   = r_result_src;
  assign ALUSrc_a_E    = r_alu_src_a;
  assign ALU_Control_E = r_alu_control;
  assign Funct3_E      = r_funct3;
  assign PC_E          = r_pc;
  assign PCPlus4_E     = r_pc_plus4;
  assign RD1_E         = r_rd1;
  assign RD2_E         = r_rd2;
  assign ImmExt_E      = r_imm_ext;
  assign Rs1_E         = r_rs1;
  assign Rs2_E         = r_rs2;
  assign Rd_E          = r_rd;

  // Load-use hazard. Rs2 is compared for every opcode; a false stall on an
  // I-type instruction costs one cycle but is never incorrect.
  assign w_lw_in_e  = r_valid & (r_result_src == 2'b01) & (r_rd != 5'd0);
  assign w_rs_match = (r_rd == Rs1_D) | (r_rd == Rs2_D);
  assign lwStall    = w_lw_in_e & valid_D & w_rs_match;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_bubble_cnt;
  logic        w_bubble;

  // An edge leaves an empty slot on a flush, an invalid load, or a stall
  // that holds an already empty slot.
  assign w_bubble = flush_E | (~stall_E & ~valid_D) | (stall_E & ~r_valid);

  // Saturating bubble counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= 32'h0;
    end else if (w_bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'h1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`else
  assign bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the stimulus process drives one directed
// vector per cycle and queues the hand-computed E-stage contents expected
// after the next rising edge; a monitor pops and compares after each edge.
module tb_id_ex_stage;

  typedef struct packed {
    logic        v;
    logic        rw;
    logic        mw;
    logic        br;
    logic        asb;
    logic [1:0]  j;
    logic [1:0]  rs;
    logic [1:0]  asa;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } slot_t;

  typedef struct packed {
    slot_t       s;
    logic        lw;
    logic [31:0] bc;
  } exp_t;

  logic clk = 1'b0;
  logic rst, valid_D, stall_E, flush_E;
  logic RegWrite_D, MemWrite_D, Branch_D, ALUSrc_b_D;
  logic [1:0] Jump_D, ResultSrc_D, ALUSrc_a_D;
  logic [3:0] ALU_Control_D;
  logic [2:0] Funct3_D;
  logic [31:0] PC_D, PCPlus4_D, RD1_D, RD2_D, ImmExt_D;
  logic [4:0] Rs1_D, Rs2_D, Rd_D;
  logic RegWrite_E, MemWrite_E, Branch_E, ALUSrc_b_E;
  logic [1:0] Jump_E, ResultSrc_E, ALUSrc_a_E;
  logic [3:0] ALU_Control_E;
  logic [2:0] Funct3_E;
  logic [31:0] PC_E, PCPlus4_E, RD1_E, RD2_E, ImmExt_E;
  logic [4:0] Rs1_E, Rs2_E, Rd_E;
  logic valid_E, lwStall;
  logic [31:0] bubble_cnt;

  int errors = 0;
  int checks = 0;
  exp_t q[$];

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .valid_D(valid_D), .stall_E(stall_E), .flush_E(flush_E),
    .RegWrite_D(RegWrite_D), .MemWrite_D(MemWrite_D), .Branch_D(Branch_D),
    .ALUSrc_b_D(ALUSrc_b_D), .Jump_D(Jump_D), .ResultSrc_D(ResultSrc_D),
    .ALUSrc_a_D(ALUSrc_a_D), .ALU_Control_D(ALU_Control_D), .Funct3_D(Funct3_D),
    .PC_D(PC_D), .PCPlus4_D(PCPlus4_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
    .ImmExt_D(ImmExt_D), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
    .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E), .Branch_E(Branch_E),
    .ALUSrc_b_E(ALUSrc_b_E), .Jump_E(Jump_E), .ResultSrc_E(ResultSrc_E),
    .ALUSrc_a_E(ALUSrc_a_E), .ALU_Control_E(ALU_Control_E), .Funct3_E(Funct3_E),
    .PC_E(PC_E), .PCPlus4_E(PCPlus4_E), .RD1_E(RD1_E), .RD2_E(RD2_E),
    .ImmExt_E(ImmExt_E), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
    .valid_E(valid_E), .lwStall(lwStall), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // Builds a decode vector; the secondary fields are filled with distinct
  // patterns derived from pc/rd1 so that every lane is exercised.
  function automatic slot_t mk(input logic v, input logic rw, input logic mw,
                               input logic br, input logic [1:0] j, input logic [1:0] rs,
                               input logic [31:0] pc, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [31:0] rd1);
    slot_t s;
    s.v   = v;   s.rw  = rw;  s.mw = mw; s.br = br;
    s.j   = j;   s.rs  = rs;
    s.asb = pc[2];
    s.asa = pc[4:3];
    s.alu = pc[7:4];
    s.f3  = pc[4:2];
    s.pc  = pc;
    s.pc4 = pc + 32'd4;
    s.rd1 = rd1;
    s.rd2 = rd1 ^ 32'h5A5A_0000;
    s.imm = {pc[29:0], 2'b01};
    s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
    return s;
  endfunction

  task automatic step(input slot_t d, input logic st, input logic fl, input logic rs,
                      input slot_t e, input logic elw, input logic [31:0] ebc);
    exp_t x;
    @(negedge clk);
    rst = rs; stall_E = st; flush_E = fl;
    valid_D = d.v; RegWrite_D = d.rw; MemWrite_D = d.mw; Branch_D = d.br;
    ALUSrc_b_D = d.asb; Jump_D = d.j; ResultSrc_D = d.rs; ALUSrc_a_D = d.asa;
    ALU_Control_D = d.alu; Funct3_D = d.f3; PC_D = d.pc; PCPlus4_D = d.pc4;
    RD1_D = d.rd1; RD2_D = d.rd2; ImmExt_D = d.imm;
    Rs1_D = d.rs1; Rs2_D = d.rs2; Rd_D = d.rd;
    x.s  = e;
    x.lw = elw;
`ifdef ID_EX_PERF_CNT_EN
    x.bc = ebc;
`else
    x.bc = 32'h0;
`endif
    q.push_back(x);
  endtask

  // Monitor: compares the E slot, lwStall and the bubble counter after each edge.
  always @(posedge clk) begin
    exp_t  x;
    slot_t act;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      act = {valid_E, RegWrite_E, MemWrite_E, Branch_E, ALUSrc_b_E, Jump_E,
             ResultSrc_E, ALUSrc_a_E, ALU_Control_E, Funct3_E, PC_E, PCPlus4_E,
             RD1_E, RD2_E, ImmExt_E, Rs1_E, Rs2_E, Rd_E};
      checks++;
      if (act !== x.s) begin
        errors++;
        $display("FAIL e_slot t=%0t got=%h exp=%h", $time, act, x.s);
      end
      checks++;
      if (lwStall !== x.lw) begin
        errors++;
        $display("FAIL lwStall t=%0t got=%b exp=%b", $time, lwStall, x.lw);
      end
      checks++;
      if (bubble_cnt !== x.bc) begin
        errors++;
        $display("FAIL bubble_cnt t=%0t got=%h exp=%h", $time, bubble_cnt, x.bc);
      end
    end
  end

  initial begin
    slot_t z, r, add3, sw, nx, inv, inv_e, lw5, use2, use1, nouse, lw0, alu5, add9;
    z = '0;
    rst = 1'b1; stall_E = 1'b0; flush_E = 1'b0; valid_D = 1'b0;
    RegWrite_D = 0; MemWrite_D = 0; Branch_D = 0; ALUSrc_b_D = 0;
    Jump_D = 0; ResultSrc_D = 0; ALUSrc_a_D = 0; ALU_Control_D = 0; Funct3_D = 0;
    PC_D = 0; PCPlus4_D = 0; RD1_D = 0; RD2_D = 0; ImmExt_D = 0;
    Rs1_D = 0; Rs2_D = 0; Rd_D = 0;

    // reset with random decode inputs
    for (int i = 0; i < 2; i++) begin
      r = mk(1'b1, 1'b1, 1'($urandom), 1'($urandom), 2'($urandom), 2'b01,
             $urandom, 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
      step(r, 1'($urandom), 1'($urandom), 1'b1, z, 1'b0, 32'd0);
    end

    // add x3,x1,x2 passes through
    add3 = mk(1, 1, 0, 0, 2'b00, 2'b00, 32'h100, 5'd1, 5'd2, 5'd3, 32'h11);
    step(add3, 0, 0, 0, add3, 1'b0, 32'd0);

    // sw then 3-cycle stall with new decode values, then flush under stall
    sw = mk(1, 0, 1, 0, 2'b00, 2'b00, 32'h104, 5'd2, 5'd4, 5'd8, 32'h22);
    step(sw, 0, 0, 0, sw, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      nx = mk(1, 1, 0, 1, 2'b01, 2'b00, 32'h200 + 32'(i * 4), 5'd7, 5'd8, 5'd9, 32'h33);
      step(nx, 1, 0, 0, sw, 1'b0, 32'd0);
    end
    step(nx, 1, 1, 0, z, 1'b0, 32'd1);

    // invalid slot: side effects masked, data captured
    inv   = mk(0, 1, 0, 0, 2'b10, 2'b00, 32'h300, 5'd1, 5'd2, 5'd7, 32'hDEAD_BEEF);
    inv_e = mk(0, 0, 0, 0, 2'b00, 2'b00, 32'h300, 5'd1, 5'd2, 5'd7, 32'hDEAD_BEEF);
    step(inv, 0, 0, 0, inv_e, 1'b0, 32'd2);

    // reset together with flush
    step(add3, 0, 1, 1, z, 1'b0, 32'd0);

    // load-use hazard cases
    lw5   = mk(1, 1, 0, 0, 2'b00, 2'b01, 32'h400, 5'd2, 5'd0, 5'd5, 32'h40);
    use2  = mk(1, 1, 0, 0, 2'b00, 2'b00, 32'h404, 5'd1, 5'd5, 5'd6, 32'h44);
    use1  = mk(1, 1, 0, 0, 2'b00, 2'b00, 32'h408, 5'd5, 5'd1, 5'd6, 32'h48);
    nouse = mk(1, 1, 0, 0, 2'b00, 2'b00, 32'h40C, 5'd6, 5'd7, 5'd8, 32'h4C);
    step(lw5, 0, 0, 0, lw5, 1'b0, 32'd0);
    step(use2, 1, 0, 0, lw5, 1'b1, 32'd0);
    step(use1, 1, 0, 0, lw5, 1'b1, 32'd0);
    use1.v = 1'b0;
    step(use1, 1, 0, 0, lw5, 1'b0, 32'd0);
    step(nouse, 1, 0, 0, lw5, 1'b0, 32'd0);
    lw0 = mk(1, 1, 0, 0, 2'b00, 2'b01, 32'h410, 5'd0, 5'd0, 5'd0, 32'h50);
    step(lw0, 0, 0, 0, lw0, 1'b0, 32'd0);
    alu5 = mk(1, 1, 0, 0, 2'b00, 2'b00, 32'h414, 5'd5, 5'd5, 5'd5, 32'h54);
    step(alu5, 0, 0, 0, alu5, 1'b0, 32'd0);

    // reset mid-stall, stall on empty slot, then load
    step(add3, 1, 0, 1, z, 1'b0, 32'd0);
    step(add3, 1, 0, 0, z, 1'b0, 32'd1);
    add9 = mk(1, 1, 0, 1, 2'b01, 2'b10, 32'h500, 5'd3, 5'd4, 5'd9, 32'h600);
    step(add9, 0, 0, 0, add9, 1'b0, 32'd1);

    // counter: 4 flushes + 2 invalid loads after reset
    step(add9, 0, 0, 1, z, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) step(add9, 0, 1, 0, z, 1'b0, 32'(i + 1));
    step(inv, 0, 0, 0, inv_e, 1'b0, 32'd5);
    step(inv, 0, 0, 0, inv_e, 1'b0, 32'd6);

`ifdef ID_EX_PERF_CNT_EN
    // saturation
    step(add9, 0, 1, 0, z, 1'b0, 32'hFFFF_FFFE);
    force dut.r_bubble_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.r_bubble_cnt;
    step(add9, 0, 1, 0, z, 1'b0, 32'hFFFF_FFFF);
    step(add9, 0, 1, 0, z, 1'b0, 32'hFFFF_FFFF);
    step(add9, 0, 0, 0, add9, 1'b0, 32'hFFFF_FFFF);
`endif

    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
